// File: rtl/write_buffer_fifo.sv
// write_buffer_fifo: multi-entry FIFO write buffer that merges partial writes, forwards reads and drains the head to AXI.
module write_buffer_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 128,
  parameter int ADDR_W = 32,
  parameter int OFF_W  = 4,
  parameter int SEL_W  = DATA_W / 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wreq_i,
  input  logic [ADDR_W-1:0]        waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [SEL_W-1:0]         wsel_i,
  output logic                     wready_o,
  output logic                     whit_o,
  input  logic                     rreq_i,
  input  logic [ADDR_W-1:0]        raddr_i,
  output logic                     rhit_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     axi_wvalid_o,
  output logic [ADDR_W-1:0]        axi_waddr_o,
  output logic [DATA_W-1:0]        axi_wdata_o,
  input  logic                     axi_wready_i
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] AMASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);
  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PW-1:0]     r_head, r_tail;
  logic [CW-1:0]     r_count;
  logic [ADDR_W-1:0] w_waddr, w_raddr;
  logic [DATA_W-1:0] w_mask;
  logic [PW-1:0]     w_widx, w_ridx, w_j;
  logic              w_whit, w_rhit, w_push, w_pop;
  assign w_waddr = waddr_i & AMASK;
  assign w_raddr = raddr_i & AMASK;
  // Walk oldest to youngest so the last match wins; the head is excluded from merging because it is locked.
  always_comb begin
    w_whit = 1'b0;
    w_rhit = 1'b0;
    w_widx = r_head;
    w_ridx = r_head;
    w_j    = r_head;
    for (int k = 0; k < DEPTH; k++) begin
      w_j = r_head + PW'(k);
      if (r_valid[w_j] && r_addr[w_j] == w_raddr) begin
        w_rhit = 1'b1;
        w_ridx = w_j;
      end
      if (k != 0 && r_valid[w_j] && r_addr[w_j] == w_waddr) begin
        w_whit = 1'b1;
        w_widx = w_j;
      end
    end
  end
  always_comb begin
    w_mask = '0;
    for (int s = 0; s < SEL_W; s++) w_mask[s*32 +: 32] = {32{wsel_i[s]}};
  end
  assign whit_o       = wreq_i & w_whit;
  assign full_o       = r_count == CW'(DEPTH);
  assign empty_o      = r_count == '0;
  assign wready_o     = wreq_i & (whit_o | ~full_o);
  assign w_push       = wready_o & ~whit_o;
  assign axi_wvalid_o = ~empty_o;
  assign w_pop        = axi_wvalid_o & axi_wready_i;
  assign axi_waddr_o  = r_addr[r_head];
  assign axi_wdata_o  = r_data[r_head];
  assign rhit_o       = rreq_i & w_rhit;
  assign rdata_o      = rhit_o ? r_data[w_ridx] : '0;
  assign count_o      = r_count;
  always_ff @(posedge clk) begin
    if (whit_o) r_data[w_widx] <= (r_data[w_widx] & ~w_mask) | (wdata_i & w_mask);
    if (w_push) begin
      r_addr[r_tail] <= w_waddr;
      r_data[r_tail] <= wdata_i;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: tb/tb_write_buffer_fifo.sv
// tb_write_buffer_fifo: scoreboard bench comparing write_buffer_fifo against a queue-based reference model.
module tb_write_buffer_fifo;
  localparam int DEPTH = 4;
  logic         clk = 1'b0, rst = 1'b1;
  logic         wreq = 0, rreq = 0, awready = 0;
  logic [31:0]  waddr = 0, raddr = 0;
  logic [127:0] wdata = 0;
  logic [3:0]   wsel = 0;
  logic         wready_o, whit_o, rhit_o, full_o, empty_o, axi_wvalid_o;
  logic [127:0] rdata_o, axi_wdata_o;
  logic [31:0]  axi_waddr_o;
  logic [2:0]   count_o;
  write_buffer_fifo dut (
    .clk(clk), .rst(rst), .wreq_i(wreq), .waddr_i(waddr), .wdata_i(wdata), .wsel_i(wsel),
    .wready_o(wready_o), .whit_o(whit_o), .rreq_i(rreq), .raddr_i(raddr), .rhit_o(rhit_o),
    .rdata_o(rdata_o), .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .axi_wvalid_o(axi_wvalid_o), .axi_waddr_o(axi_waddr_o), .axi_wdata_o(axi_wdata_o),
    .axi_wready_i(awready)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] a; logic [127:0] d;} ent_t;
  typedef struct packed {
    logic wready, whit, rhit; logic [127:0] rdata; logic [2:0] cnt;
    logic full, empty, wvalid; logic [31:0] waddr; logic [127:0] wdata;
  } exp_t;
  ent_t m_q[$], drain_q[$], m_d;
  exp_t exp_q[$], m_e;
  int n_pass = 0, n_tot = 0;
  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      chk("wready", wready_o, m_e.wready);
      chk("whit", whit_o, m_e.whit);
      chk("rhit", rhit_o, m_e.rhit);
      chk("rdata", rdata_o, m_e.rdata);
      chk("count", count_o, m_e.cnt);
      chk("full", full_o, m_e.full);
      chk("empty", empty_o, m_e.empty);
      chk("wvalid", axi_wvalid_o, m_e.wvalid);
      if (m_e.wvalid) begin
        chk("head_addr", axi_waddr_o, m_e.waddr);
        chk("head_data", axi_wdata_o, m_e.wdata);
      end
    end
    if (axi_wvalid_o && awready && !rst) begin
      if (drain_q.size() == 0) chk("drain_unexpected", 1'b1, 1'b0);
      else begin
        m_d = drain_q.pop_front();
        chk("drain_addr", axi_waddr_o, m_d.a);
        chk("drain_data", axi_wdata_o, m_d.d);
      end
    end
  end
  task automatic drive(input logic w, input logic [31:0] a, input logic [127:0] d, input logic [3:0] s,
                       input logic r, input logic [31:0] ra, input logic ar);
    wreq = w; waddr = a; wdata = d; wsel = s; rreq = r; raddr = ra; awready = ar;
  endtask
  // Reference model: the queue front is the head; youngest match is the highest index.
  task automatic step();
    exp_t e;
    ent_t t;
    int hj, rj;
    logic [31:0] aw, ar;
    logic hit, full, wr, pop;
    aw = waddr & ~32'hF;
    ar = raddr & ~32'hF;
    full = m_q.size() == DEPTH;
    hj = -1;
    rj = -1;
    for (int i = 1; i < m_q.size(); i++) if (m_q[i].a == aw) hj = i;
    for (int i = 0; i < m_q.size(); i++) if (m_q[i].a == ar) rj = i;
    hit = wreq && hj >= 0;
    wr = wreq && (hit || !full);
    pop = m_q.size() > 0 && awready;
    e = '0;
    e.wready = wr;
    e.whit = hit;
    e.rhit = rreq && rj >= 0;
    e.rdata = e.rhit ? m_q[rj].d : 128'h0;
    e.cnt = 3'(m_q.size());
    e.full = full;
    e.empty = m_q.size() == 0;
    e.wvalid = !e.empty;
    if (!e.empty) begin
      e.waddr = m_q[0].a;
      e.wdata = m_q[0].d;
    end
    exp_q.push_back(e);
    if (rst) m_q.delete();
    else begin
      if (hit) begin
        t = m_q[hj];
        for (int s = 0; s < 4; s++) if (wsel[s]) t.d[s*32 +: 32] = wdata[s*32 +: 32];
        m_q[hj] = t;
      end
      if (pop) drain_q.push_back(m_q.pop_front());
      if (wr && !hit) begin
        t.a = aw;
        t.d = wdata;
        m_q.push_back(t);
      end
    end
    @(posedge clk);
    #1;
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  localparam logic [31:0] A = 32'h1000_0010, B = 32'h2000_0000;
  logic [127:0] da, da2, db, dw;
  initial begin
    da = {4{32'hAAAA_AAAA}};
    da2 = rnd128();
    db = rnd128();
    dw = {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0};
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    drive(0, 0, 0, 0, 1, A, 0);
    #1;
    chk("reset_count", count_o, 0);
    chk("reset_empty", empty_o, 1);
    chk("reset_wvalid", axi_wvalid_o, 0);
    step();
    drive(1, A, da, 4'h0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("first_wvalid", axi_wvalid_o, 1);
    chk("first_waddr", axi_waddr_o, A);
    chk("first_count", count_o, 1);
    step();
    drive(1, B, db, 4'h0, 0, 0, 0); step();
    drive(1, B + 32'h4, dw, 4'b0010, 0, 0, 0);
    #1;
    chk("merge_whit", whit_o, 1);
    step();
    drive(0, 0, 0, 0, 1, B, 0);
    #1;
    chk("merge_word1", rdata_o[63:32], 32'hDEAD_BEEF);
    chk("merge_word0", rdata_o[31:0], db[31:0]);
    chk("merge_count", count_o, 2);
    step();
    drive(1, A, da2, 4'hF, 0, 0, 0);
    #1;
    chk("head_dup_whit", whit_o, 0);
    step();
    drive(0, 0, 0, 0, 1, A, 0);
    #1;
    chk("dup_read", rdata_o, da2);
    step();
    drive(0, 0, 0, 0, 0, 0, 1); step();
    drive(0, 0, 0, 0, 1, A, 0); step();
    drive(1, 32'h5000_0000, rnd128(), 0, 0, 0, 0); step();
    drive(1, 32'h5000_0010, rnd128(), 0, 0, 0, 0); step();
    drive(1, 32'h5000_0020, rnd128(), 0, 0, 0, 1);
    #1;
    chk("full_refuse", wready_o, 0);
    step();
    drive(1, 32'h5000_0020, rnd128(), 0, 0, 0, 0);
    #1;
    chk("retry_count", count_o, 3);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("retry_full", count_o, 4);
    repeat (4) begin drive(0, 0, 0, 0, 0, 0, 1); step(); end
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h3000_0000 + 32'(i * 16), rnd128(), 0, 0, 0, 1);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 1); step();
    chk("wrap_empty", empty_o, 1);
    for (int i = 0; i < 3; i++) begin drive(1, 32'h6000_0000 + 32'(i * 16), rnd128(), 0, 0, 0, 0); step(); end
    rst = 1;
    drive(0, 0, 0, 0, 0, 0, 1); step();
    rst = 0;
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 1, 32'h6000_0000 + 32'(i * 16), 0); step(); end
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom % 150) == 0;
      drive($urandom % 3 != 0, 32'h4000_0000 + 32'(($urandom % 6) * 16 + $urandom % 16), rnd128(),
            4'($urandom), $urandom % 2 == 0, 32'h4000_0000 + 32'(($urandom % 6) * 16), ($urandom % 3) == 0);
      step();
    end
    rst = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("drain_q_empty", 32'(drain_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
